// File: rtl/pwm_cmp_demux_8ch_pkg.sv
// Shared types for the 8-channel double-buffered PWM compare distributor.
// Supplies the count width if the surrounding build has not defined it.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package pwm_cmp_demux_8ch_pkg;
  localparam int PWM_NCH = 8;
  localparam int PWM_W   = `PWMCOUNT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    XFER = 2'd2
  } pwm_demux_state_t;

  function automatic logic [PWM_NCH-1:0] sel_decode(input logic [2:0] sel);
    logic [PWM_NCH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction
endpackage

// File: rtl/pwm_shadow_reg.sv
// One channel: shadow register written at any time, copied to the active
// register on commit only if the channel has a pending write.
module pwm_shadow_reg
  import pwm_cmp_demux_8ch_pkg::*;
#(
  parameter logic [PWM_W-1:0] DEFAULT_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [PWM_W-1:0] wr_dat_i,
  input  logic             commit_i,
  output logic [PWM_W-1:0] active_o,
  output logic             pending_o
);
  logic [PWM_W-1:0] shadow_q, shadow_d;
  logic [PWM_W-1:0] active_q, active_d;
  logic             pending_q, pending_d;

  always_comb begin
    shadow_d  = wr_en_i ? wr_dat_i : shadow_q;
    active_d  = (commit_i && pending_q) ? shadow_q : active_q;
    pending_d = pending_q;
    if (wr_en_i)       pending_d = 1'b1;
    else if (commit_i) pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q  <= DEFAULT_VAL;
      active_q  <= DEFAULT_VAL;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;
endmodule

// File: rtl/pwm_cmp_demux_8ch.sv
// 1-to-8 double-buffered PWM compare distributor: writes land in shadows,
// a load strobe commits all pending shadows at once. Clamp option: PWM_DEMUX_CLAMP_EN.
module pwm_cmp_demux_8ch
  import pwm_cmp_demux_8ch_pkg::*;
#(
  parameter logic [`PWMCOUNT_WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [`PWMCOUNT_WIDTH-1:0] in_0,
  input  logic [2:0]                 sel_0,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       load,
  input  logic [`PWMCOUNT_WIDTH-1:0] period_max,
  output logic [`PWMCOUNT_WIDTH-1:0] out_0,
  output logic [`PWMCOUNT_WIDTH-1:0] out_1,
  output logic [`PWMCOUNT_WIDTH-1:0] out_2,
  output logic [`PWMCOUNT_WIDTH-1:0] out_3,
  output logic [`PWMCOUNT_WIDTH-1:0] out_4,
  output logic [`PWMCOUNT_WIDTH-1:0] out_5,
  output logic [`PWMCOUNT_WIDTH-1:0] out_6,
  output logic [`PWMCOUNT_WIDTH-1:0] out_7,
  output logic [7:0]                 pending,
  output logic                       clamped
);
  pwm_demux_state_t   state_q;
  logic               wr_acc;
  logic               commit;
  logic [PWM_NCH-1:0] wr_en_vec;
  logic [PWM_W-1:0]   wr_dat;
  logic [PWM_W-1:0]   act [PWM_NCH];

  assign wr_ready  = (state_q != XFER);
  assign wr_acc    = wr_valid && wr_ready;
  assign commit    = (state_q == XFER);
  assign wr_en_vec = wr_acc ? sel_decode(sel_0) : '0;

`ifdef PWM_DEMUX_CLAMP_EN
  logic clamped_q;

  assign wr_dat = (in_0 > period_max) ? period_max : in_0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            clamped_q <= 1'b0;
    else if (wr_acc && in_0 > period_max) clamped_q <= 1'b1;
  end

  assign clamped = clamped_q;
`else
  logic [PWM_W-1:0] unused_period_max;

  assign unused_period_max = period_max;
  assign wr_dat            = in_0;
  assign clamped           = 1'b0;
`endif

  // IDLE ignores load so an empty pending set never costs a blocked cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (wr_acc) state_q <= PEND;
        PEND:    if (load)   state_q <= XFER;
        XFER:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < PWM_NCH; i++) begin : g_ch
    pwm_shadow_reg #(.DEFAULT_VAL(DEFAULT_VAL)) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en_i  (wr_en_vec[i]),
      .wr_dat_i (wr_dat),
      .commit_i (commit),
      .active_o (act[i]),
      .pending_o(pending[i])
    );
  end

  assign out_0 = act[0];
  assign out_1 = act[1];
  assign out_2 = act[2];
  assign out_3 = act[3];
  assign out_4 = act[4];
  assign out_5 = act[5];
  assign out_6 = act[6];
  assign out_7 = act[7];
endmodule
